mem_arbiter: RTL and testbench

- Shares the single-port instruction/data RAM between two requesters: the instruction-fetch port (IR load) and the load/store data port (LDR/STR).
- Sequences each RAM access: arbitration, address/strobe issue, read-latency wait, response.
- Sits between the CPU controller/datapath and the RAM; replaces fixed memory/memory_wait stalls with a req/gnt/rvalid handshake.

---
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter and sequencer for a single-port RAM
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of data priority with starvation guard.
module mem_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_w_en,
   output logic              ram_rd_en,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   logic [1:0]        state_q, state_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic              owner_q, owner_d;          // 1 = data port
   logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
   logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_w_en_q, ram_w_en_d, ram_rd_en_q, ram_rd_en_d;
   logic              busy_q, busy_d;
   logic              fetch_pri;
   logic              pick_f;

`ifdef MEM_ARB_RR_EN
   logic last_owner_q, last_owner_d;               // 1 = data won last
   assign fetch_pri = last_owner_q;
`else
   localparam int SC_W = $clog2(STARVE_MAX + 1);
   logic [SC_W-1:0] starve_q, starve_d;
   assign fetch_pri = (starve_q == SC_W'(STARVE_MAX));
`endif

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      owner_d     = owner_q;
      if_gnt_d    = 1'b0;
      d_gnt_d     = 1'b0;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_w_en_d  = 1'b0;
      ram_rd_en_d = 1'b0;
      busy_d      = busy_q;
      pick_f      = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_d = last_owner_q;
`else
      starve_d     = starve_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (if_req || d_req) begin
               pick_f  = if_req && (!d_req || fetch_pri);
               state_d = S_ISSUE;
               busy_d  = 1'b1;
               owner_d = !pick_f;
               if (pick_f) begin
                  if_gnt_d    = 1'b1;
                  ram_addr_d  = if_addr;
                  ram_rd_en_d = 1'b1;
               end else begin
                  d_gnt_d    = 1'b1;
                  ram_addr_d = d_addr;
                  if (d_we) begin
                     ram_w_en_d  = 1'b1;
                     ram_wdata_d = d_wdata;
                  end else begin
                     ram_rd_en_d = 1'b1;
                  end
               end
`ifdef MEM_ARB_RR_EN
               last_owner_d = !pick_f;
`else
               // Only contested data wins age the fetch port.
               if (pick_f)
                  starve_d = '0;
               else if (if_req && !fetch_pri)
                  starve_d = starve_q + 1'b1;
`endif
            end
         end
         S_ISSUE: begin
            if (ram_w_en_q) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = S_WAIT;
               wcnt_d  = WC_W'(RD_LAT - 1);
            end
         end
         S_WAIT: begin
            if (wcnt_q == '0) begin
               state_d = S_RESP;
               if (owner_q) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = ram_rdata;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = ram_rdata;
               end
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wcnt_q      <= '0;
         owner_q     <= 1'b0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_w_en_q  <= 1'b0;
         ram_rd_en_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= 1'b1;
`else
         starve_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         owner_q     <= owner_d;
         if_gnt_q    <= if_gnt_d;
         d_gnt_q     <= d_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_w_en_q  <= ram_w_en_d;
         ram_rd_en_q <= ram_rd_en_d;
         busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= last_owner_d;
`else
         starve_q     <= starve_d;
`endif
      end
   end

   assign if_gnt    = if_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_w_en  = ram_w_en_q;
   assign ram_rd_en = ram_rd_en_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter with a latency-modelled RAM
module tb_mem_arbiter;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0, d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic              if_gnt, if_rvalid, d_gnt, d_rvalid, ram_w_en, ram_rd_en, busy;
   logic [DATA_W-1:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
   logic [ADDR_W-1:0] ram_addr;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_w_en(ram_w_en), .ram_rd_en(ram_rd_en),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM: data for the address presented in cycle N appears in cycle N+RD_LAT
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] pipe [RD_LAT];
   always @(posedge clk) begin
      if (ram_w_en) mem[ram_addr] <= ram_wdata;
      pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_rdata = pipe[RD_LAT-1];

   int checks = 0;
   int errors = 0;
   logic [32:0] sb [$];   // {is_data, expected rdata}

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] all_outs();
      return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
              ram_addr, ram_wdata, ram_w_en, ram_rd_en, busy};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_excl", {255'd0, if_gnt & d_gnt}, '0);
         chk("strobe_excl", {255'd0, ram_w_en & ram_rd_en}, '0);
         if (if_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
               chk("rvalid_unexpected", 256'd1, 256'd0);
            end else begin
               logic [32:0] e;
               e = sb.pop_front();
               chk("rvalid_port", {254'd0, d_rvalid, if_rvalid}, {254'd0, e[32], !e[32]});
               chk("rvalid_data", d_rvalid ? d_rdata : if_rdata, e[31:0]);
            end
         end
      end
   end

   task automatic wait_rv(input bit is_d);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(is_d ? d_rvalid : if_rvalid) && n < 20);
      chk("rvalid_timeout", {255'd0, is_d ? d_rvalid : if_rvalid}, 256'd1);
   endtask

   string exp_order;
   int    grants;
   int    n;
   int    seen_rv;

   initial begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'h0;
      mem[11'h010] = 32'hE3A01005;
      mem[11'h011] = 32'h12345678;
      mem[11'h012] = 32'hA5A50012;
`ifdef MEM_ARB_RR_EN
      exp_order = "DFDFDFDFDF";
`else
      exp_order = "DDDDFDDDDF";
`endif

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outs", all_outs(), '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", all_outs(), '0);

      // Fetch read of 0x010: gnt next cycle, rvalid RD_LAT+2 cycles after grant cycle's predecessor
      if_req = 1'b1; if_addr = 11'h010;
      sb.push_back({1'b0, 32'hE3A01005});
      @(negedge clk);
      chk("f_gnt", {253'd0, if_gnt, d_gnt, ram_rd_en}, {253'd0, 3'b101});
      chk("f_addr", {245'd0, ram_addr}, {245'd0, 11'h010});
      chk("f_busy", {255'd0, busy}, 256'd1);
      if_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("f_rv_early", {255'd0, if_rvalid}, 256'd0);
      @(negedge clk);
      chk("f_rv_cycle4", {254'd0, if_rvalid, d_rvalid}, {254'd0, 2'b10});
      @(negedge clk);
      chk("f_idle", {255'd0, busy}, 256'd0);

      // Data write 0x200
      d_req = 1'b1; d_we = 1'b1; d_addr = 11'h200; d_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("w_strobes", {252'd0, d_gnt, if_gnt, ram_w_en, ram_rd_en}, {252'd0, 4'b1010});
      chk("w_addr", {245'd0, ram_addr}, {245'd0, 11'h200});
      chk("w_wdata", ram_wdata, 32'hDEADBEEF);
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("w_no_rvalid", {254'd0, if_rvalid, d_rvalid}, '0);
      chk("w_idle", {255'd0, busy}, 256'd0);

      // Data read back 0x200
      d_req = 1'b1; d_addr = 11'h200;
      sb.push_back({1'b1, 32'hDEADBEEF});
      @(negedge clk);
      chk("dr_gnt", {254'd0, d_gnt, ram_rd_en}, {254'd0, 2'b11});
      d_req = 1'b0;
      wait_rv(1'b1);
      chk("if_rdata_hold", if_rdata, 32'hE3A01005);

      // Fetch 0x011 so the fetch port is the most recent owner
      @(negedge clk);
      if_req = 1'b1; if_addr = 11'h011;
      sb.push_back({1'b0, 32'h12345678});
      @(negedge clk);
      if_req = 1'b0;
      wait_rv(1'b0);
      chk("d_rdata_hold", d_rdata, 32'hDEADBEEF);
      @(negedge clk);

      // Contention: both held continuously
      if_req = 1'b1; if_addr = 11'h010;
      d_req = 1'b1; d_we = 1'b1; d_addr = 11'h300; d_wdata = 32'h0BADF00D;
      grants = 0; n = 0;
      while (grants < 10 && n < 300) begin
         @(negedge clk);
         n++;
         if (if_gnt || d_gnt) begin
            if (if_gnt) sb.push_back({1'b0, 32'hE3A01005});
            chk($sformatf("grant_order_%0d", grants), {248'd0, d_gnt ? 8'h44 : 8'h46},
                {248'd0, 8'(exp_order[grants])});
            grants++;
         end
      end
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if (grants < 10) chk("grant_timeout", grants, 10);
      repeat (RD_LAT + 4) @(negedge clk);

      // Write cut by reset during ISSUE
      d_req = 1'b1; d_we = 1'b1; d_addr = 11'h201; d_wdata = 32'h11111111;
      @(negedge clk);
      chk("wc_gnt", {255'd0, d_gnt}, 256'd1);
      rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
      #1;
      chk("wc_reset_outs", all_outs(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("wc_no_gnt", {254'd0, d_gnt, if_gnt}, '0);

      // Fetch read cut by reset during WAIT: must never produce rvalid
      if_req = 1'b1; if_addr = 11'h012;
      @(negedge clk);
      chk("fr_gnt", {255'd0, if_gnt}, 256'd1);
      if_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("fr_reset_outs", all_outs(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_rv = 0;
      repeat (RD_LAT + 4) begin
         @(negedge clk);
         if (if_rvalid || d_rvalid) seen_rv++;
      end
      chk("fr_no_rvalid", seen_rv, 0);

      // Same read serviced normally after reset
      if_req = 1'b1; if_addr = 11'h012;
      sb.push_back({1'b0, 32'hA5A50012});
      @(negedge clk);
      if_req = 1'b0;
      wait_rv(1'b0);
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
